// File: rtl/rm_encode_writer_pkg.sv
// Shared constants for the encode-side codeword writer.
// The parameter-set helpers map the HQC security level to N1_BYTES, MULT,
// N and the number of 128-bit words written. The FSM state encoding is
// also defined here.
package rm_encode_writer_pkg;

    // Output word width. It is fixed to the RM(1,7) codeword length.
    localparam int RAMWIDTH = 128;

    // Encoder sequencing states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        PAD   = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Reed-Solomon codeword length in bytes. ps is the security level:
    // 128, 192 or 256.
    function automatic int n1_bytes(input int ps);
        case (ps)
            192:     return 56;
            256:     return 90;
            default: return 46;
        endcase
    endfunction

    // Reed-Muller duplication factor.
    function automatic int rm_mult(input int ps);
        case (ps)
            192:     return 5;
            256:     return 5;
            default: return 3;
        endcase
    endfunction

    // Code length in bits.
    function automatic int code_len(input int ps);
        case (ps)
            192:     return 35851;
            256:     return 57637;
            default: return 17669;
        endcase
    endfunction

    // Number of RAMWIDTH words needed to hold n bits. n is rounded up to a
    // whole word.
    function automatic int ram_depth(input int n);
        return (n + (RAMWIDTH - n % RAMWIDTH) % RAMWIDTH) / RAMWIDTH;
    endfunction

endpackage

// File: rtl/rm_encode_writer_rm17.sv
// Combinational RM(1,7) encoder. It maps one message byte to a 128-bit
// codeword.
// Output bit i is m[7] XOR the parity of (m[6:0] AND i[6:0]).
// This equals the all-ones row selected by m[7], XORed with generator
// row j for each set bit m[j]. Generator row j has bit i = i[j].
module rm17_encode
    import rm_encode_writer_pkg::*;
(
    input  logic [7:0]          msg,
    output logic [RAMWIDTH-1:0] code
);

    localparam logic [RAMWIDTH-1:0] ROW [7] = '{
        {16{8'hAA}},
        {16{8'hCC}},
        {16{8'hF0}},
        {8{16'hFF00}},
        {4{32'hFFFF_0000}},
        {2{64'hFFFF_FFFF_0000_0000}},
        {{64{1'b1}}, {64{1'b0}}}
    };

    // Build the codeword as the XOR of the generator rows selected by msg.
    always_comb begin
        code = {RAMWIDTH{msg[7]}};
        for (int j = 0; j < 7; j++) begin
            if (msg[j]) begin
                code = code ^ ROW[j];
            end
        end
    end

endmodule

// File: rtl/rm_encode_writer.sv
// Encode-side codeword writer.
// For each RS codeword byte, the block fetches the byte and RM(1,7)
// encodes it. It then writes the 128-bit result MULT times to consecutive
// RAM words. After the last byte it appends zero padding words up to
// RAMDEPTH, then pulses done.
//
// State table:
//   IDLE  | wait for start
//   FETCH | issue the byte read (cw_rd_en, cw_addr)
//   LOAD  | capture cw_byte and latch its RM codeword
//   WRITE | write the codeword MULT times
//   PAD   | write the zero words that fill out the last RAM word range
//   DONE  | one-cycle done pulse; busy is low
//
// All outputs are registered. Their next values are decoded from the next
// state, so each output lines up with the state it belongs to.
// wr_data doubles as the codeword register. It holds the codeword across
// all MULT writes of one byte and is zero during padding.
module rm_encode_writer
    import rm_encode_writer_pkg::*;
#(
    parameter  int PARAM_SET    = 128,
    localparam int N1_BYTES     = n1_bytes(PARAM_SET),
    localparam int MULT         = rm_mult(PARAM_SET),
    localparam int N            = code_len(PARAM_SET),
    localparam int RAMDEPTH     = ram_depth(N),
    localparam int LOG_N1_BYTES = $clog2(N1_BYTES),
    localparam int LOG_RAMDEPTH = $clog2(RAMDEPTH)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    cw_rd_en,
    output logic [LOG_N1_BYTES-1:0] cw_addr,
    input  logic [7:0]              cw_byte,
    output logic                    wr_en,
    output logic [LOG_RAMDEPTH-1:0] wr_addr,
    output logic [RAMWIDTH-1:0]     wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam int PAD_WORDS = RAMDEPTH - N1_BYTES * MULT;
    localparam int REP_W     = 4;

    localparam logic [REP_W-1:0]        REP_LAST  = REP_W'(MULT - 1);
    localparam logic [REP_W-1:0]        PAD_LAST  = REP_W'(PAD_WORDS - 1);
    localparam logic [LOG_N1_BYTES-1:0] BYTE_LAST = LOG_N1_BYTES'(N1_BYTES - 1);

    state_t                  state, state_nxt;
    logic [LOG_N1_BYTES-1:0] byte_cnt, byte_cnt_nxt;
    logic [REP_W-1:0]        rep_cnt, rep_cnt_nxt;
    logic [LOG_RAMDEPTH-1:0] word_addr, word_addr_nxt;
    logic [RAMWIDTH-1:0]     code_word;

    logic                    cw_rd_en_nxt;
    logic [LOG_N1_BYTES-1:0] cw_addr_nxt;
    logic                    wr_en_nxt;
    logic [LOG_RAMDEPTH-1:0] wr_addr_nxt;
    logic [RAMWIDTH-1:0]     wr_data_nxt;
    logic                    busy_nxt;
    logic                    done_nxt;

    rm17_encode u_rm17 (
        .msg  (cw_byte),
        .code (code_word)
    );

    // State and sequencing counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            rep_cnt   <= '0;
            word_addr <= '0;
        end else begin
            state     <= state_nxt;
            byte_cnt  <= byte_cnt_nxt;
            rep_cnt   <= rep_cnt_nxt;
            word_addr <= word_addr_nxt;
        end
    end

    // Next state, counter updates and codeword capture.
    always_comb begin
        state_nxt     = state;
        byte_cnt_nxt  = byte_cnt;
        rep_cnt_nxt   = rep_cnt;
        word_addr_nxt = word_addr;
        wr_data_nxt   = wr_data;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = FETCH;
                    byte_cnt_nxt  = '0;
                    rep_cnt_nxt   = '0;
                    word_addr_nxt = '0;
                end
            end
            FETCH: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                wr_data_nxt = code_word;
                rep_cnt_nxt = '0;
                state_nxt   = WRITE;
            end
            WRITE: begin
                word_addr_nxt = word_addr + 1'b1;
                if (rep_cnt == REP_LAST) begin
                    rep_cnt_nxt = '0;
                    if (byte_cnt == BYTE_LAST) begin
                        wr_data_nxt = '0;
                        state_nxt   = PAD;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 1'b1;
                        state_nxt    = FETCH;
                    end
                end else begin
                    rep_cnt_nxt = rep_cnt + 1'b1;
                end
            end
            PAD: begin
                // The last padding word holds the address so it stays at RAMDEPTH-1.
                if (rep_cnt == PAD_LAST) begin
                    rep_cnt_nxt = '0;
                    state_nxt   = DONE;
                end else begin
                    rep_cnt_nxt   = rep_cnt + 1'b1;
                    word_addr_nxt = word_addr + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Decode next-cycle output values from the next state.
    always_comb begin
        cw_rd_en_nxt = (state_nxt == FETCH);
        cw_addr_nxt  = byte_cnt_nxt;
        wr_en_nxt    = (state_nxt == WRITE) || (state_nxt == PAD);
        wr_addr_nxt  = wr_en_nxt ? word_addr_nxt : '0;
        busy_nxt     = (state_nxt != IDLE) && (state_nxt != DONE);
        done_nxt     = (state_nxt == DONE);
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_rd_en <= 1'b0;
            cw_addr  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            cw_rd_en <= cw_rd_en_nxt;
            cw_addr  <= cw_addr_nxt;
            wr_en    <= wr_en_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_rm_encode_writer.sv
// Bench for rm_encode_writer. It runs an hqc128 instance and an hqc256
// instance. Each instance has a one-cycle-latency byte source and a write
// monitor. Captured streams are compared with a bit-level RM(1,7) model.
module tb_rm_encode_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         a_start = 1'b0, a_cw_rd_en, a_wr_en, a_busy, a_done;
    logic [5:0]   a_cw_addr;
    logic [7:0]   a_cw_byte = 8'h00;
    logic [7:0]   a_wr_addr;
    logic [127:0] a_wr_data;

    logic         b_start = 1'b0, b_cw_rd_en, b_wr_en, b_busy, b_done;
    logic [6:0]   b_cw_addr;
    logic [7:0]   b_cw_byte = 8'h00;
    logic [8:0]   b_wr_addr;
    logic [127:0] b_wr_data;

    rm_encode_writer #(.PARAM_SET(128)) dut_a (
        .clk(clk), .rst(rst), .start(a_start),
        .cw_rd_en(a_cw_rd_en), .cw_addr(a_cw_addr), .cw_byte(a_cw_byte),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done)
    );

    rm_encode_writer #(.PARAM_SET(256)) dut_b (
        .clk(clk), .rst(rst), .start(b_start),
        .cw_rd_en(b_cw_rd_en), .cw_addr(b_cw_addr), .cw_byte(b_cw_byte),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   mem [2][90];
    logic [127:0] got [2][512];
    logic [127:0] expw [512];
    int  wr_cnt [2], addr_err [2], done_cnt [2], done_cyc [2], busy_gap [2], s_edge [2];
    bit  active [2], done_bz [2];
    int  edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Byte sources. Data appears exactly one cycle after the read strobe;
    // at any other time the bus carries junk.
    logic       a_pv = 1'b0, b_pv = 1'b0;
    logic [7:0] a_pend = 8'h00, b_pend = 8'h00;
    always @(negedge clk) begin
        a_cw_byte = a_pv ? a_pend : 8'($urandom);
        a_pv      = a_cw_rd_en;
        a_pend    = mem[0][a_cw_addr];
        b_cw_byte = b_pv ? b_pend : 8'($urandom);
        b_pv      = b_cw_rd_en;
        b_pend    = mem[1][b_cw_addr];
    end

    task automatic sample(input int idx, input logic we, input logic [8:0] wa,
                          input logic [127:0] wd, input logic dn, input logic bz);
        if (we) begin
            if (int'(wa) != wr_cnt[idx]) addr_err[idx]++;
            if (wr_cnt[idx] < 512) got[idx][wr_cnt[idx]] = wd;
            wr_cnt[idx]++;
        end
        if (dn) begin
            done_cnt[idx]++;
            done_cyc[idx] = edge_cnt - s_edge[idx];
            done_bz[idx]  = bz;
            active[idx]   = 1'b0;
        end else if (active[idx] && !bz) begin
            busy_gap[idx]++;
        end
    endtask

    // Write monitors.
    always @(negedge clk) begin
        sample(0, a_wr_en, 9'(a_wr_addr), a_wr_data, a_done, a_busy);
        sample(1, b_wr_en, b_wr_addr, b_wr_data, b_done, b_busy);
    end

    // Reference RM(1,7): bit i = m[7] ^ parity(m[6:0] & i).
    function automatic logic [127:0] rm_ref(input logic [7:0] m);
        logic [127:0] c;
        for (int i = 0; i < 128; i++) begin
            int ones = 0;
            for (int j = 0; j < 7; j++) if (m[j] && ((i >> j) & 1) == 1) ones++;
            c[i] = m[7] ^ ones[0];
        end
        return c;
    endfunction

    // Expected output stream: each byte repeated mult times, then zero padding.
    task automatic build_exp(input int idx, input int nb, input int m, input int depth);
        for (int w = 0; w < 512; w++) expw[w] = '0;
        for (int k = 0; k < nb; k++)
            for (int r = 0; r < m; r++) expw[k*m + r] = rm_ref(mem[idx][k]);
        for (int w = nb*m; w < depth; w++) expw[w] = '0;
    endtask

    task automatic set_start(input int idx, input logic v);
        if (idx == 0) a_start = v; else b_start = v;
    endtask

    task automatic clear_mon(input int idx);
        wr_cnt[idx] = 0; addr_err[idx] = 0; done_cnt[idx] = 0;
        done_cyc[idx] = -1; busy_gap[idx] = 0; done_bz[idx] = 1'b0; active[idx] = 1'b0;
    endtask

    // Start one job. Optionally pulse start again at cycles g1/g2. Wait,
    // with a cycle bound, for done, then a few cycles more.
    task automatic run_job(input int idx, input int g1, input int g2);
        int c;
        clear_mon(idx);
        @(negedge clk);
        s_edge[idx] = edge_cnt;
        set_start(idx, 1'b1);
        @(negedge clk);
        set_start(idx, 1'b0);
        active[idx] = 1'b1;
        c = 1;
        while (done_cnt[idx] == 0 && c < 1000) begin
            @(negedge clk);
            c++;
            set_start(idx, (c == g1) || (c == g2));
        end
        set_start(idx, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if ({a_cw_rd_en, a_wr_en, a_busy, a_done} !== 4'b0) begin miscompares++; $display("FAIL reset_a_ctrl: got %b exp 0000", {a_cw_rd_en, a_wr_en, a_busy, a_done}); end
        vectors++; if (a_wr_addr !== 8'd0 || a_cw_addr !== 6'd0) begin miscompares++; $display("FAIL reset_a_addr: got %0d/%0d exp 0/0", a_wr_addr, a_cw_addr); end
        vectors++; if (a_wr_data !== 128'd0) begin miscompares++; $display("FAIL reset_a_data: got %h exp 0", a_wr_data); end
        vectors++; if ({b_cw_rd_en, b_wr_en, b_busy, b_done} !== 4'b0) begin miscompares++; $display("FAIL reset_b_ctrl: got %b exp 0000", {b_cw_rd_en, b_wr_en, b_busy, b_done}); end
        vectors++; if (b_wr_addr !== 9'd0 || b_cw_addr !== 7'd0 || b_wr_data !== 128'd0) begin miscompares++; $display("FAIL reset_b_out: got %0d/%0d/%h exp 0", b_wr_addr, b_cw_addr, b_wr_data); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // All-zero source on hqc128: timing, count and data.
    task automatic test_zero;
        for (int k = 0; k < 90; k++) mem[0][k] = 8'h00;
        build_exp(0, 46, 3, 139);
        run_job(0, 0, 0);
        vectors++; if (wr_cnt[0] !== 139) begin miscompares++; $display("FAIL zero_count: got %0d exp 139", wr_cnt[0]); end
        vectors++; if (addr_err[0] !== 0) begin miscompares++; $display("FAIL zero_addr_seq: got %0d errors exp 0", addr_err[0]); end
        vectors++; if (done_cyc[0] !== 232) begin miscompares++; $display("FAIL zero_done_cycle: got %0d exp 232", done_cyc[0]); end
        vectors++; if (done_cnt[0] !== 1 || done_bz[0] !== 1'b0) begin miscompares++; $display("FAIL zero_done_pulse: got %0d pulses busy=%b exp 1 busy=0", done_cnt[0], done_bz[0]); end
        vectors++; if (busy_gap[0] !== 0) begin miscompares++; $display("FAIL zero_busy: got %0d idle cycles exp 0", busy_gap[0]); end
        for (int w = 0; w < 139; w++) begin
            vectors++; if (got[0][w] !== expw[w]) begin miscompares++; $display("FAIL zero_data[%0d]: got %h exp %h", w, got[0][w], expw[w]); end
        end
    endtask

    // Directed first bytes plus a random source on hqc128.
    task automatic test_patterns;
        logic [7:0]   pat [4];
        logic [127:0] known [3];
        pat[0] = 8'h80; pat[1] = 8'h01; pat[2] = 8'h40; pat[3] = 8'h00;
        known[0] = {128{1'b1}};
        known[1] = {16{8'hAA}};
        known[2] = {{64{1'b1}}, {64{1'b0}}};
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 90; k++) mem[0][k] = (p == 3) ? 8'($urandom) : 8'h00;
            if (p < 3) mem[0][0] = pat[p];
            build_exp(0, 46, 3, 139);
            run_job(0, 0, 0);
            vectors++; if (wr_cnt[0] !== 139 || addr_err[0] !== 0) begin miscompares++; $display("FAIL pat%0d_count: got %0d (%0d addr errors) exp 139", p, wr_cnt[0], addr_err[0]); end
            if (p < 3) begin
                for (int r = 0; r < 3; r++) begin
                    vectors++; if (got[0][r] !== known[p]) begin miscompares++; $display("FAIL pat%0d_const[%0d]: got %h exp %h", p, r, got[0][r], known[p]); end
                end
            end
            for (int w = 0; w < 139; w++) begin
                vectors++; if (got[0][w] !== expw[w]) begin miscompares++; $display("FAIL pat%0d_data[%0d]: got %h exp %h", p, w, got[0][w], expw[w]); end
            end
        end
    endtask

    // Random source on hqc256.
    task automatic test_random256;
        for (int k = 0; k < 90; k++) mem[1][k] = 8'($urandom);
        build_exp(1, 90, 5, 451);
        run_job(1, 0, 0);
        vectors++; if (wr_cnt[1] !== 451 || addr_err[1] !== 0) begin miscompares++; $display("FAIL r256_count: got %0d (%0d addr errors) exp 451", wr_cnt[1], addr_err[1]); end
        vectors++; if (done_cyc[1] !== 632) begin miscompares++; $display("FAIL r256_done_cycle: got %0d exp 632", done_cyc[1]); end
        vectors++; if (got[1][450] !== 128'd0) begin miscompares++; $display("FAIL r256_pad: got %h exp 0", got[1][450]); end
        for (int w = 0; w < 451; w++) begin
            vectors++; if (got[1][w] !== expw[w]) begin miscompares++; $display("FAIL r256_data[%0d]: got %h exp %h", w, got[1][w], expw[w]); end
        end
    endtask

    // A start pulse while the block is busy must not restart the job.
    task automatic test_start_while_busy;
        for (int k = 0; k < 90; k++) mem[0][k] = 8'($urandom);
        build_exp(0, 46, 3, 139);
        run_job(0, 10, 100);
        vectors++; if (wr_cnt[0] !== 139 || addr_err[0] !== 0) begin miscompares++; $display("FAIL busy_start_count: got %0d (%0d addr errors) exp 139", wr_cnt[0], addr_err[0]); end
        vectors++; if (done_cyc[0] !== 232 || done_cnt[0] !== 1) begin miscompares++; $display("FAIL busy_start_done: got cycle %0d x%0d exp 232 x1", done_cyc[0], done_cnt[0]); end
        for (int w = 0; w < 139; w++) begin
            vectors++; if (got[0][w] !== expw[w]) begin miscompares++; $display("FAIL busy_start_data[%0d]: got %h exp %h", w, got[0][w], expw[w]); end
        end
    endtask

    // Reset in the middle of a job, then a clean run from byte 0 / address 0.
    task automatic test_reset_mid;
        for (int k = 0; k < 90; k++) mem[0][k] = 8'($urandom);
        build_exp(0, 46, 3, 139);
        clear_mon(0);
        @(negedge clk);
        s_edge[0] = edge_cnt;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        while (edge_cnt - s_edge[0] < 50) @(negedge clk);
        rst = 1'b1;
        active[0] = 1'b0;
        #1;
        vectors++; if ({a_cw_rd_en, a_wr_en, a_busy, a_done} !== 4'b0) begin miscompares++; $display("FAIL midrst_ctrl: got %b exp 0000", {a_cw_rd_en, a_wr_en, a_busy, a_done}); end
        vectors++; if (a_wr_addr !== 8'd0 || a_cw_addr !== 6'd0 || a_wr_data !== 128'd0) begin miscompares++; $display("FAIL midrst_out: got %0d/%0d/%h exp 0", a_wr_addr, a_cw_addr, a_wr_data); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (done_cnt[0] !== 0 || a_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_no_done: got %0d pulses busy=%b exp 0 busy=0", done_cnt[0], a_busy); end
        run_job(0, 0, 0);
        vectors++; if (wr_cnt[0] !== 139 || addr_err[0] !== 0 || done_cyc[0] !== 232) begin miscompares++; $display("FAIL midrst_rerun: got %0d writes %0d addr errors done %0d exp 139/0/232", wr_cnt[0], addr_err[0], done_cyc[0]); end
        for (int w = 0; w < 139; w++) begin
            vectors++; if (got[0][w] !== expw[w]) begin miscompares++; $display("FAIL midrst_data[%0d]: got %h exp %h", w, got[0][w], expw[w]); end
        end
    endtask

    // A start in the done cycle is ignored: the block stays idle.
    task automatic test_back_to_back;
        int c;
        clear_mon(0);
        @(negedge clk);
        s_edge[0] = edge_cnt;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        c = 0;
        while (a_done !== 1'b1 && c < 1000) begin @(negedge clk); c++; end
        vectors++; if (a_done !== 1'b1) begin miscompares++; $display("FAIL b2b_done_seen: got %b exp 1", a_done); end
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (6) @(negedge clk);
        vectors++; if (a_busy !== 1'b0 || a_cw_rd_en !== 1'b0) begin miscompares++; $display("FAIL b2b_ignored: got busy=%b rd=%b exp 0/0", a_busy, a_cw_rd_en); end
        vectors++; if (wr_cnt[0] !== 139) begin miscompares++; $display("FAIL b2b_count: got %0d exp 139", wr_cnt[0]); end
    endtask

    initial begin
        for (int k = 0; k < 90; k++) begin mem[0][k] = 8'h00; mem[1][k] = 8'h00; end
        clear_mon(0);
        clear_mon(1);
        test_reset;
        test_zero;
        test_patterns;
        test_random256;
        test_start_while_busy;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
